// File: rtl/blink_pkg.sv
// Shared types and defaults for the multi-channel LED blinker.
package blink_pkg;
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    PULSE = 2'd3
  } mode_e;

  localparam int CBITS_DEF    = 11;
  localparam int CHANNELS_DEF = 4;
endpackage

// File: rtl/blink_chan.sv
// One LED channel: mode register plus blink phase and pulse flop, led decoded from state.
// Optional SVA compiled in when BLINK_ASSERT_EN is defined.
//
// state | meaning
// OFF   | led held low
// ON    | led held high
// BLINK | ph toggles on each channel event, led = ph
// PULSE | led high for the one cycle after each channel event
module blink_chan
  import blink_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrap,
  input  logic       ev,
  input  logic [1:0] mode_req,
  output logic       led
);

  mode_e mode_q, mode_d, req;
  logic  ph_q, ph_d;
  logic  pls_q, pls_d;

  assign req = mode_e'(mode_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= OFF;
      ph_q   <= 1'b0;
      pls_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      ph_q   <= ph_d;
      pls_q  <= pls_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    ph_d   = ph_q;
    pls_d  = 1'b0;
    led    = 1'b0;
    // A mode change at a wrap restarts the channel and swallows any coincident event.
    if (wrap && (req != mode_q)) begin
      mode_d = req;
      ph_d   = 1'b0;
    end else begin
      case (mode_q)
        BLINK:   if (ev) ph_d = !ph_q;
        PULSE:   pls_d = ev;
        default: ;
      endcase
    end
    case (mode_q)
      ON:      led = 1'b1;
      BLINK:   led = ph_q;
      PULSE:   led = pls_q;
      default: led = 1'b0;
    endcase
  end

`ifdef BLINK_ASSERT_EN
  a_off: assert property (@(posedge clk) disable iff (!rst_n)
    (mode_q == OFF) |-> !led);
  a_live: assert property (@(posedge clk) disable iff (!rst_n)
    (mode_q == BLINK && $stable(mode_q)) |-> s_eventually led);
`endif

endmodule

// File: rtl/blink_multi.sv
// Shared prescaler, epoch counter and per-channel event decode driving CHANNELS LED channels.
// Optional SVA compiled in when BLINK_ASSERT_EN is defined.
module blink_multi
  import blink_pkg::*;
#(
  parameter int CBITS    = CBITS_DEF,
  parameter int CHANNELS = CHANNELS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*CHANNELS-1:0] mode_i,
  output logic [CHANNELS-1:0]   led,
  output logic                  flg
);

  localparam logic [CBITS-1:0]    CNT_ONE = 1;
  localparam logic [CHANNELS-1:0] EP_ONE  = 1;

  logic [CBITS-1:0]    cnt;
  logic [CHANNELS-1:0] epoch;
  logic [CHANNELS-1:0] ev;
  logic [CHANNELS-1:0] msk;
  logic                wrap;

  assign wrap = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      epoch <= '0;
      flg   <= 1'b0;
    end else begin
      cnt <= cnt + CNT_ONE;
      flg <= wrap;
      if (wrap) epoch <= epoch + EP_ONE;
    end
  end

  // Channel i fires on every 2^i-th wrap, using the epoch value before it increments.
  always_comb begin
    ev  = '0;
    msk = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      msk = '0;
      for (int j = 0; j < i; j++) msk[j] = 1'b1;
      ev[i] = wrap && ((epoch & msk) == msk);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    blink_chan u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wrap     (wrap),
      .ev       (ev[i]),
      .mode_req (mode_i[2*i +: 2]),
      .led      (led[i])
    );
  end

`ifdef BLINK_ASSERT_EN
  a_flg: assert property (@(posedge clk) disable iff (!rst_n) flg |=> !flg);
`endif

endmodule

// File: tb/tb_blink_multi.sv
// Randomized and directed bench for blink_multi with an edge-count reference model.
module tb_blink_multi;
  localparam int CB = 3;
  localparam int CH = 2;
  localparam int P  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2*CH-1:0] mode_i = '0;
  logic [CH-1:0] led;
  logic          flg;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  int m_mode[CH];
  int m_evs[CH];
  int m_last[CH];

  blink_multi #(.CBITS(CB), .CHANNELS(CH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode_i (mode_i),
    .led    (led),
    .flg    (flg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  function automatic int exp_led();
    int v;
    v = 0;
    for (int i = 0; i < CH; i++) begin
      if (m_mode[i] == 1) v |= (1 << i);
      if (m_mode[i] == 2 && (m_evs[i] % 2) == 1) v |= (1 << i);
      if (m_mode[i] == 3 && m_last[i] == n) v |= (1 << i);
    end
    return v;
  endfunction

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 0;
      m_evs[i]  = 0;
      m_last[i] = -1;
    end
  endtask

  // Edge n is a wrap edge when n is a multiple of 2^CBITS; wrap number w feeds channel i when 2^i divides w.
  task automatic model_edge(input logic [2*CH-1:0] m_in);
    int w;
    int req;
    n++;
    if (n % P == 0) begin
      w = n / P;
      for (int i = 0; i < CH; i++) begin
        req = int'(m_in[2*i +: 2]);
        if (req != m_mode[i]) begin
          m_mode[i] = req;
          m_evs[i]  = 0;
          m_last[i] = -1;
        end else if (w % (1 << i) == 0) begin
          m_evs[i]++;
          m_last[i] = n;
        end
      end
    end
  endtask

  task automatic step();
    logic [2*CH-1:0] m_in;
    m_in = mode_i;
    @(posedge clk);
    model_edge(m_in);
    #1;
    chk("led", led, exp_led());
    chk("flg", flg, (n % P == 0) ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_led", led, 0);
    chk("rst_flg", flg, 0);
    chk("rst_cnt", dut.cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_s2();
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 8)  chk("s2_led8", led, 0);
      if (e == 16) chk("s2_led16", led, 3);
      if (e == 24) chk("s2_led24", led, 1 << 1);
      if (e == 32) chk("s2_led32", led, 1);
    end
  endtask

  initial begin
    model_reset();

    // idle
    mode_i = '0;
    do_reset();
    repeat (40) step();

    // both channels blinking from reset
    mode_i = 4'b1010;
    do_reset();
    run_s2();

    // pulse on ch0
    mode_i = 4'b0011;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 16 || e == 24 || e == 32) chk("s3_pulse", led, 1);
      if (e == 17) chk("s3_pulse_end", led, 0);
    end

    // blink ch0, request OFF mid-period
    mode_i = 4'b0010;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 19) mode_i = 4'b0000;
      if (e == 23) chk("s4_hold", led, 1);
      if (e == 24) chk("s4_off", led, 0);
    end

    // ON for ch1 requested at edge 10
    mode_i = 4'b0000;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 10) mode_i = 4'b0100;
      if (e == 15) chk("s5_wait", led, 0);
      if (e == 16) chk("s5_on", led, 2);
    end

    // async reset mid-blink
    mode_i = 4'b1010;
    do_reset();
    repeat (20) step();
    chk("s6_pre", led[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_led", led, 0);
    chk("s6_flg", flg, 0);
    chk("s6_cnt", dut.cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_s2();

    // random mode traffic
    mode_i = 4'(($urandom));
    do_reset();
    for (int e = 0; e < 3000; e++) begin
      step();
      if ($urandom_range(0, 11) == 0) mode_i = 4'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
